spdif_frame_assembler: RTL and testbench
========================================

// Module: spdif_frame_assembler
// PURPOSE
//  Consumes decoded subframes from the S/PDIF receiver (spdif_dai) and pairs
//  channel A/B subframes into stereo samples behind a valid/ack handshake.
//  Tracks 192-frame block sync via B/M/W preambles, checks subframe parity and
//  collects the 192-bit channel-status block. Sits between spdif_dai and the
//  mixer input FIFO.
// PARAMETERS
//  AUDIO_W      24  audio bits per subframe; data_i is AUDIO_W+4 bits wide
//  LOCK_BLOCKS  1   error-free complete blocks required before lock_o rises
// PORTS
//  clk          in   1          system clock
//  rst          in   1          reset, asynchronous, active-low
//  data_i       in   AUDIO_W+4  {P,C,U,V,audio[AUDIO_W-1:0]} from spdif_dai
//  preamble_i   in   2          0=B, 1=M, 2=W, 3=invalid; qualified by we_i
//  we_i         in   1          one-cycle strobe: data_i/preamble_i valid
//  data_l_o     out  AUDIO_W    channel A (left) audio of held pair
//  data_r_o     out  AUDIO_W    channel B (right) audio of held pair
//  perr_o       out  1          held pair contained a parity error
//  valid_o      out  1          pair held in output register
//  ack_i        in   1          consumer accepts pair when valid_o&ack_i
//  overrun_o    out  1          1-cycle pulse: unacked pair overwritten
//  sync_err_o   out  1          1-cycle pulse: unexpected preamble
//  cs_o         out  192        channel status; cs_o[n] = C bit of frame n
//  cs_valid_o   out  1          1-cycle pulse: cs_o updated
//  lock_o       out  1          block sync established
// BEHAVIOUR
//  - Reset: all outputs 0, state HUNT, frame_cnt 0, lock count 0.
//  - Parity: subframe ok iff ^data_i == 0 (even parity over bits 4..31).
//  - FSM (advances only on we_i):
//    HUNT : B -> store left, frame_cnt=0, go RIGHT; M/W/3 -> ignored, no err.
//    LEFT : expect B iff frame_cnt==191 (then frame_cnt=0), else M
//           (frame_cnt+1). Match -> store left, go RIGHT.
//    RIGHT: expect W. Match -> load output pair, go LEFT.
//    Any mismatch in LEFT/RIGHT: sync_err_o pulse, stored left dropped,
//    lock_o=0, lock count=0, cs shift cleared, go HUNT; that subframe is NOT
//    re-evaluated as a B in the same cycle.
//  - Output load on W strobe at cycle t: at t+1 data_l_o/data_r_o/perr_o
//    updated, valid_o=1; perr_o = left parity bad | right parity bad.
//  - Load while valid_o=1 and no ack that cycle: overwrite, overrun_o at t+1.
//    Load and ack same cycle: load wins, valid_o stays 1, no overrun.
//  - Ack without load: valid_o=0 next cycle; data outputs hold last value.
//  - Channel status: C bit of each left subframe written to cs_shift[frame_cnt].
//    After frame 191 left subframe: cs_o <= cs_shift, cs_valid_o pulses at t+1.
//  - Lock: each error-free block (frame 0..191 and no sync_err) increments
//    lock count (saturating); lock_o=1 once count >= LOCK_BLOCKS, set in the
//    same cycle as cs_valid_o. Parity errors do not drop lock.
//  - Pairs are delivered whether or not lock_o=1, once out of HUNT.
//  - Reset mid-frame: immediate return to reset state; held pair discarded.
// TESTING
//  1 Reset pulse low -> all outputs 0; no valid_o for M/W-only input.
//  2 B{audio=24'hdeadff} then W{24'h00beef}, good parity -> 1 cycle after W:
//    valid_o=1, data_l_o=deadff, data_r_o=00beef, perr_o=0.
//  3 192 frames (B first, M after), left C bits = 1 on frames 0,2,191 ->
//    cs_valid_o pulse, cs_o bits 0,2,191 set only, lock_o=1.
//  4 Flip P of a right subframe -> that pair perr_o=1, lock_o unaffected.
//  5 W following W -> sync_err_o pulse, lock_o=0, no pair; next B resyncs.
//  6 Two pairs, ack_i held 0 -> overrun_o pulse, second pair visible;
//    ack and load in same cycle -> valid_o stays 1, no overrun_o.

Source files
------------

// File: rtl/spdif_frame_assembler.sv
// S/PDIF frame assembler: pairs A/B subframes into stereo samples, tracks
// 192-frame block sync from B/M/W preambles, checks parity and gathers channel status.
module spdif_frame_assembler #(
  parameter int AUDIO_W     = 24,
  parameter int LOCK_BLOCKS = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [AUDIO_W+3:0] data_i,
  input  logic [1:0]         preamble_i,
  input  logic               we_i,
  output logic [AUDIO_W-1:0] data_l_o,
  output logic [AUDIO_W-1:0] data_r_o,
  output logic               perr_o,
  output logic               valid_o,
  input  logic               ack_i,
  output logic               overrun_o,
  output logic               sync_err_o,
  output logic [191:0]       cs_o,
  output logic               cs_valid_o,
  output logic               lock_o
);

  localparam logic [1:0] PRE_B      = 2'd0;
  localparam logic [1:0] PRE_M      = 2'd1;
  localparam logic [1:0] PRE_W      = 2'd2;
  localparam logic [7:0] LAST_FRAME = 8'd191;
  localparam int         LOCK_W     = (LOCK_BLOCKS < 1) ? 1 : $clog2(LOCK_BLOCKS + 1);
  localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCK_BLOCKS);

  typedef enum logic [1:0] {
    ST_HUNT  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2
  } state_e;

  state_e              r_state;
  state_e              w_state_next;
  logic [7:0]          r_frame_cnt;
  logic [7:0]          w_frame_next;
  logic [1:0]          w_expect_pre;
  logic                w_accept_left;
  logic                w_load_pair;
  logic                w_sync_err;
  logic                w_block_done;
  logic                w_par_bad;
  logic                w_c_bit;
  logic [191:0]        w_cs_next;
  logic [LOCK_W-1:0]   w_lock_inc;

  logic [AUDIO_W-1:0]  r_left_audio;
  logic                r_left_perr;
  logic [191:0]        r_cs_shift;
  logic [LOCK_W-1:0]   r_lock_cnt;
  logic [AUDIO_W-1:0]  r_data_l;
  logic [AUDIO_W-1:0]  r_data_r;
  logic                r_perr;
  logic                r_valid;
  logic                r_overrun;
  logic                r_sync_err;
  logic [191:0]        r_cs;
  logic                r_cs_valid;
  logic                r_lock;

  assign w_par_bad = ^data_i;
  assign w_c_bit   = data_i[AUDIO_W+2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_HUNT;
    else      r_state <= w_state_next;
  end

  // NOTE: every combinational output gets a default first so no path leaves a latch.
  always_comb begin
    w_state_next  = r_state;
    w_frame_next  = r_frame_cnt;
    w_expect_pre  = PRE_M;
    w_accept_left = 1'b0;
    w_load_pair   = 1'b0;
    w_sync_err    = 1'b0;
    if (we_i) begin
      unique case (r_state)
        ST_HUNT: begin
          if (preamble_i == PRE_B) begin
            w_accept_left = 1'b1;
            w_frame_next  = 8'd0;
            w_state_next  = ST_RIGHT;
          end
        end
        ST_LEFT: begin
          if (r_frame_cnt == LAST_FRAME) begin
            w_expect_pre = PRE_B;
            w_frame_next = 8'd0;
          end else begin
            w_frame_next = r_frame_cnt + 8'd1;
          end
          if (preamble_i == w_expect_pre) begin
            w_accept_left = 1'b1;
            w_state_next  = ST_RIGHT;
          end else begin
            w_sync_err   = 1'b1;
            w_state_next = ST_HUNT;
          end
        end
        ST_RIGHT: begin
          if (preamble_i == PRE_W) begin
            w_load_pair  = 1'b1;
            w_state_next = ST_LEFT;
          end else begin
            w_sync_err   = 1'b1;
            w_state_next = ST_HUNT;
          end
        end
        default: w_state_next = ST_HUNT;
      endcase
    end
  end

  // A block is complete when the left subframe of frame 191 is accepted; the
  // FSM only reaches that count by walking up from a B with no sync error.
  assign w_block_done = w_accept_left && (w_frame_next == LAST_FRAME);
  assign w_lock_inc   = (r_lock_cnt == LOCK_MAX) ? r_lock_cnt : r_lock_cnt + 1'b1;

  always_comb begin
    w_cs_next               = (w_frame_next == 8'd0) ? '0 : r_cs_shift;
    w_cs_next[w_frame_next] = w_c_bit;
  end

  // NOTE: state registers use non-blocking assignment so all update on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_frame_cnt  <= '0;
      r_left_audio <= '0;
      r_left_perr  <= 1'b0;
      r_cs_shift   <= '0;
      r_cs         <= '0;
      r_cs_valid   <= 1'b0;
      r_lock_cnt   <= '0;
      r_lock       <= 1'b0;
      r_sync_err   <= 1'b0;
    end else begin
      r_cs_valid <= w_block_done;
      r_sync_err <= w_sync_err;
      if (w_accept_left) begin
        r_frame_cnt  <= w_frame_next;
        r_left_audio <= data_i[AUDIO_W-1:0];
        r_left_perr  <= w_par_bad;
        r_cs_shift   <= w_cs_next;
      end
      if (w_block_done) begin
        r_cs       <= w_cs_next;
        r_lock_cnt <= w_lock_inc;
        r_lock     <= (w_lock_inc == LOCK_MAX);
      end
      if (w_sync_err) begin
        r_cs_shift <= '0;
        r_lock_cnt <= '0;
        r_lock     <= 1'b0;
      end
    end
  end

  // Output pair register: a new load always wins over a same-cycle ack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data_l  <= '0;
      r_data_r  <= '0;
      r_perr    <= 1'b0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (w_load_pair) begin
        r_data_l  <= r_left_audio;
        r_data_r  <= data_i[AUDIO_W-1:0];
        r_perr    <= r_left_perr | w_par_bad;
        r_valid   <= 1'b1;
        r_overrun <= r_valid & ~ack_i;
      end else if (ack_i) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign data_l_o   = r_data_l;
  assign data_r_o   = r_data_r;
  assign perr_o     = r_perr;
  assign valid_o    = r_valid;
  assign overrun_o  = r_overrun;
  assign sync_err_o = r_sync_err;
  assign cs_o       = r_cs;
  assign cs_valid_o = r_cs_valid;
  assign lock_o     = r_lock;

endmodule

// File: tb/tb_spdif_frame_assembler.sv
// Directed bench for spdif_frame_assembler: a vector table for pairing, parity,
// overrun and sync errors, plus sequences for a full 192-frame block and reset.
module tb_spdif_frame_assembler;

  localparam logic [1:0] B = 2'd0, M = 2'd1, W = 2'd2, X = 2'd3;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [27:0]  data_i = '0;
  logic [1:0]   preamble_i = '0;
  logic         we_i = 1'b0;
  logic         ack_i = 1'b0;
  logic [23:0]  data_l_o, data_r_o;
  logic         perr_o, valid_o, overrun_o, sync_err_o, cs_valid_o, lock_o;
  logic [191:0] cs_o;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  spdif_frame_assembler #(.AUDIO_W(24), .LOCK_BLOCKS(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_i     (data_i),
    .preamble_i (preamble_i),
    .we_i       (we_i),
    .data_l_o   (data_l_o),
    .data_r_o   (data_r_o),
    .perr_o     (perr_o),
    .valid_o    (valid_o),
    .ack_i      (ack_i),
    .overrun_o  (overrun_o),
    .sync_err_o (sync_err_o),
    .cs_o       (cs_o),
    .cs_valid_o (cs_valid_o),
    .lock_o     (lock_o)
  );

  typedef struct {
    logic        we;
    logic [1:0]  pre;
    logic [23:0] aud;
    logic        badp;
    logic        ack;
    logic        ev;
    logic [23:0] el;
    logic [23:0] er;
    logic        ep;
    logic        es;
    logic        eo;
  } vec_t;

  vec_t vecs[26];

  function automatic vec_t mk(logic we, logic [1:0] pre, logic [23:0] aud, logic badp,
                              logic ack, logic ev, logic [23:0] el, logic [23:0] er,
                              logic ep, logic es, logic eo);
    vec_t v;
    v.we = we; v.pre = pre; v.aud = aud; v.badp = badp; v.ack = ack;
    v.ev = ev; v.el = el; v.er = er; v.ep = ep; v.es = es; v.eo = eo;
    return v;
  endfunction

  // Subframe {P,C,U,V,audio} with even parity unless badp flips P.
  function automatic logic [27:0] sf(logic [23:0] aud, logic c, logic badp);
    logic [26:0] r;
    r = {c, 1'b0, 1'b0, aud};
    return {(^r) ^ badp, r};
  endfunction

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick(input logic we, input logic [1:0] pre, input logic [27:0] d, input logic ack);
    we_i = we; preamble_i = pre; data_i = d; ack_i = ack;
    @(posedge clk);
    #1;
    we_i = 1'b0; ack_i = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " valid"},    192'(valid_o),    192'(0));
    check({tag, " data_l"},   192'(data_l_o),   192'(0));
    check({tag, " data_r"},   192'(data_r_o),   192'(0));
    check({tag, " perr"},     192'(perr_o),     192'(0));
    check({tag, " overrun"},  192'(overrun_o),  192'(0));
    check({tag, " sync_err"}, 192'(sync_err_o), 192'(0));
    check({tag, " cs"},       cs_o,             192'(0));
    check({tag, " cs_valid"}, 192'(cs_valid_o), 192'(0));
    check({tag, " lock"},     192'(lock_o),     192'(0));
  endtask

  initial begin
    logic [191:0] exp_cs;
    int           early_pulses;
    logic         c;

    //              we pre aud        bp ack  ev el         er         ep es eo
    vecs[0]  = mk(0, B, 24'h000000, 0, 0,  0, 24'h000000, 24'h000000, 0, 0, 0);
    vecs[1]  = mk(1, M, 24'h123456, 0, 0,  0, 24'h000000, 24'h000000, 0, 0, 0);
    vecs[2]  = mk(1, W, 24'h654321, 0, 0,  0, 24'h000000, 24'h000000, 0, 0, 0);
    vecs[3]  = mk(1, B, 24'hdeadff, 0, 0,  0, 24'h000000, 24'h000000, 0, 0, 0);
    vecs[4]  = mk(1, W, 24'h00beef, 0, 0,  1, 24'hdeadff, 24'h00beef, 0, 0, 0);
    vecs[5]  = mk(0, B, 24'h000000, 0, 1,  0, 24'hdeadff, 24'h00beef, 0, 0, 0);
    vecs[6]  = mk(1, M, 24'h111111, 0, 0,  0, 24'hdeadff, 24'h00beef, 0, 0, 0);
    vecs[7]  = mk(1, W, 24'h222222, 1, 0,  1, 24'h111111, 24'h222222, 1, 0, 0);
    vecs[8]  = mk(0, B, 24'h000000, 0, 1,  0, 24'h111111, 24'h222222, 1, 0, 0);
    vecs[9]  = mk(1, M, 24'h333333, 0, 0,  0, 24'h111111, 24'h222222, 1, 0, 0);
    vecs[10] = mk(1, W, 24'h444444, 0, 0,  1, 24'h333333, 24'h444444, 0, 0, 0);
    vecs[11] = mk(1, M, 24'h555555, 0, 0,  1, 24'h333333, 24'h444444, 0, 0, 0);
    vecs[12] = mk(1, W, 24'h666666, 0, 0,  1, 24'h555555, 24'h666666, 0, 0, 1);
    vecs[13] = mk(1, M, 24'h777777, 0, 0,  1, 24'h555555, 24'h666666, 0, 0, 0);
    vecs[14] = mk(1, W, 24'h888888, 0, 1,  1, 24'h777777, 24'h888888, 0, 0, 0);
    vecs[15] = mk(0, B, 24'h000000, 0, 1,  0, 24'h777777, 24'h888888, 0, 0, 0);
    vecs[16] = mk(1, W, 24'h999999, 0, 0,  0, 24'h777777, 24'h888888, 0, 1, 0);
    vecs[17] = mk(0, B, 24'h000000, 0, 0,  0, 24'h777777, 24'h888888, 0, 0, 0);
    vecs[18] = mk(1, M, 24'h121212, 0, 0,  0, 24'h777777, 24'h888888, 0, 0, 0);
    vecs[19] = mk(1, B, 24'haaaaaa, 0, 0,  0, 24'h777777, 24'h888888, 0, 0, 0);
    vecs[20] = mk(1, W, 24'hbbbbbb, 0, 0,  1, 24'haaaaaa, 24'hbbbbbb, 0, 0, 0);
    vecs[21] = mk(1, W, 24'hcccccc, 0, 1,  0, 24'haaaaaa, 24'hbbbbbb, 0, 1, 0);
    vecs[22] = mk(0, B, 24'h000000, 0, 0,  0, 24'haaaaaa, 24'hbbbbbb, 0, 0, 0);
    vecs[23] = mk(1, B, 24'hdddddd, 0, 0,  0, 24'haaaaaa, 24'hbbbbbb, 0, 0, 0);
    vecs[24] = mk(1, X, 24'heeeeee, 0, 0,  0, 24'haaaaaa, 24'hbbbbbb, 0, 1, 0);
    vecs[25] = mk(0, B, 24'h000000, 0, 0,  0, 24'haaaaaa, 24'hbbbbbb, 0, 0, 0);

    #2;
    check_all_zero("reset");
    #10 rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 26; i++) begin
      tick(vecs[i].we, vecs[i].pre, sf(vecs[i].aud, 1'b0, vecs[i].badp), vecs[i].ack);
      check($sformatf("row%0d valid", i),    192'(valid_o),    192'(vecs[i].ev));
      check($sformatf("row%0d data_l", i),   192'(data_l_o),   192'(vecs[i].el));
      check($sformatf("row%0d data_r", i),   192'(data_r_o),   192'(vecs[i].er));
      check($sformatf("row%0d perr", i),     192'(perr_o),     192'(vecs[i].ep));
      check($sformatf("row%0d sync_err", i), 192'(sync_err_o), 192'(vecs[i].es));
      check($sformatf("row%0d overrun", i),  192'(overrun_o),  192'(vecs[i].eo));
      check($sformatf("row%0d lock", i),     192'(lock_o),     192'(0));
    end

    // Full block from HUNT: C set on frames 0, 2 and 191.
    exp_cs = '0;
    exp_cs[0] = 1'b1; exp_cs[2] = 1'b1; exp_cs[191] = 1'b1;
    early_pulses = 0;
    for (int f = 0; f < 192; f++) begin
      c = (f == 0) || (f == 2) || (f == 191);
      tick(1'b1, (f == 0) ? B : M, sf(24'(f), c, 1'b0), 1'b1);
      if (f == 191) begin
        check("block cs_valid", 192'(cs_valid_o), 192'(1));
        check("block cs_o",     cs_o,             exp_cs);
        check("block lock",     192'(lock_o),     192'(1));
      end else begin
        if (cs_valid_o || lock_o || sync_err_o) early_pulses++;
      end
      tick(1'b1, W, sf(24'(f + 1000), 1'b0, 1'b0), 1'b1);
      if (f == 191) check("block cs_valid drop", 192'(cs_valid_o), 192'(0));
    end
    check("block early pulses", 192'(early_pulses), 192'(0));
    check("block last left",    192'(data_l_o),     192'(191));
    check("block last right",   192'(data_r_o),     192'(1191));

    // Next block starts with B, then a right subframe with a flipped P bit.
    tick(1'b1, B, sf(24'h0a0a0a, 1'b0, 1'b0), 1'b1);
    check("wrap sync_err", 192'(sync_err_o), 192'(0));
    check("wrap lock",     192'(lock_o),     192'(1));
    tick(1'b1, W, sf(24'h0b0b0b, 1'b0, 1'b1), 1'b1);
    check("perr pair",     192'(perr_o),     192'(1));
    check("perr valid",    192'(valid_o),    192'(1));
    check("perr lock",     192'(lock_o),     192'(1));

    // W following W drops lock and yields no pair; the next B resyncs.
    tick(1'b1, W, sf(24'h0c0c0c, 1'b0, 1'b0), 1'b1);
    check("ww sync_err",   192'(sync_err_o), 192'(1));
    check("ww lock",       192'(lock_o),     192'(0));
    check("ww valid",      192'(valid_o),    192'(0));
    check("ww cs_o kept",  cs_o,             exp_cs);
    tick(1'b1, B, sf(24'h0d0d0d, 1'b0, 1'b0), 1'b0);
    check("resync sync_err", 192'(sync_err_o), 192'(0));
    tick(1'b1, W, sf(24'h0e0e0e, 1'b0, 1'b0), 1'b0);
    check("resync valid",  192'(valid_o),    192'(1));
    check("resync data_l", 192'(data_l_o),   192'(24'h0d0d0d));
    check("resync data_r", 192'(data_r_o),   192'(24'h0e0e0e));

    // Reset mid-frame with a held pair, then a lone W must not produce a pair.
    tick(1'b1, M, sf(24'h0f0f0f, 1'b0, 1'b0), 1'b0);
    rst = 1'b0;
    #1;
    check_all_zero("midreset");
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    tick(1'b1, W, sf(24'h121212, 1'b0, 1'b0), 1'b0);
    check("post-reset W valid",    192'(valid_o),    192'(0));
    check("post-reset W sync_err", 192'(sync_err_o), 192'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
